// File: rtl/pwm_capture.sv
// pwm_capture: decodes a complementary gate-drive pair into period, C_1 high time
// and dead time per switching cycle, and flags shoot-through and a stalled PWM.
module pwm_capture #(
  parameter int CNT_W   = 10,
  parameter int DT_W    = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             EN,
  input  logic             C_1,
  input  logic             C_2,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [DT_W-1:0]  dead_cnt,
  output logic             meas_valid,
  output logic             overlap_fault,
  output logic             stalled
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_ONE    = DT_W'(1);

  state_t state_q, state_d;

  logic c1_m_q, c1_s_q, c1_d_q;
  logic c2_m_q, c2_s_q;
  logic rise, both_high, both_low, timeout_hit;

  logic [CNT_W-1:0] per_acc_q, per_acc_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [DT_W-1:0]  dead_acc_q, dead_acc_d;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [DT_W-1:0]  dead_q, dead_d;
  logic             valid_q, valid_d;
  logic             overlap_q, overlap_d;
  logic             stalled_q, stalled_d;

  // Two-flop synchronizers on both gate signals, plus one extra C_1 stage for edge detect.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      c1_m_q <= 1'b0;
      c1_s_q <= 1'b0;
      c1_d_q <= 1'b0;
      c2_m_q <= 1'b0;
      c2_s_q <= 1'b0;
    end else begin
      c1_m_q <= C_1;
      c1_s_q <= c1_m_q;
      c1_d_q <= c1_s_q;
      c2_m_q <= C_2;
      c2_s_q <= c2_m_q;
    end
  end

  assign rise        = c1_s_q & ~c1_d_q;
  assign both_high   = c1_s_q & c2_s_q;
  assign both_low    = ~c1_s_q & ~c2_s_q;
  assign timeout_hit = (per_acc_q == TIMEOUT_C);

  always_comb begin
    state_d    = state_q;
    per_acc_d  = per_acc_q;
    high_acc_d = high_acc_q;
    dead_acc_d = dead_acc_q;
    period_d   = period_q;
    high_d     = high_q;
    dead_d     = dead_q;
    valid_d    = 1'b0;
    overlap_d  = overlap_q | both_high;
    stalled_d  = stalled_q & ~rise;

    case (state_q)
      IDLE: begin
        per_acc_d  = '0;
        high_acc_d = '0;
        dead_acc_d = '0;
        if (EN && rise) begin
          state_d    = ARMED;
          per_acc_d  = CNT_ONE;
          high_acc_d = CNT_ONE;
        end
      end
      ARMED, RUN: begin
        if (!EN) begin
          state_d    = IDLE;
          per_acc_d  = '0;
          high_acc_d = '0;
          dead_acc_d = '0;
        end else if (rise) begin
          // The rising-edge cycle itself belongs to the new period, hence restart at 1.
          state_d    = RUN;
          period_d   = per_acc_q;
          high_d     = high_acc_q;
          dead_d     = dead_acc_q;
          valid_d    = 1'b1;
          per_acc_d  = CNT_ONE;
          high_acc_d = CNT_ONE;
          dead_acc_d = '0;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          stalled_d  = 1'b1;
          per_acc_d  = '0;
          high_acc_d = '0;
          dead_acc_d = '0;
        end else begin
          if (per_acc_q != '1) per_acc_d = per_acc_q + CNT_ONE;
          if (c1_s_q && (high_acc_q != '1)) high_acc_d = high_acc_q + CNT_ONE;
          if (both_low && (dead_acc_q != '1)) dead_acc_d = dead_acc_q + DT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      per_acc_q  <= '0;
      high_acc_q <= '0;
      dead_acc_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      dead_q     <= '0;
      valid_q    <= 1'b0;
      overlap_q  <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_acc_q  <= per_acc_d;
      high_acc_q <= high_acc_d;
      dead_acc_q <= dead_acc_d;
      period_q   <= period_d;
      high_q     <= high_d;
      dead_q     <= dead_d;
      valid_q    <= valid_d;
      overlap_q  <= overlap_d;
      stalled_q  <= stalled_d;
    end
  end

  assign period_cnt    = period_q;
  assign high_cnt      = high_q;
  assign dead_cnt      = dead_q;
  assign meas_valid    = valid_q;
  assign overlap_fault = overlap_q;
  assign stalled       = stalled_q;

endmodule
